// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and load-extension helper for the data-memory controller.
package dmem_pkg;

    localparam logic [2:0] OPR_LB  = 3'b000;
    localparam logic [2:0] OPR_LH  = 3'b001;
    localparam logic [2:0] OPR_LW  = 3'b010;
    localparam logic [2:0] OPR_LBU = 3'b100;
    localparam logic [2:0] OPR_LHU = 3'b101;

    localparam logic [3:0] OPW_B = 4'b0001;
    localparam logic [3:0] OPW_H = 4'b0011;
    localparam logic [3:0] OPW_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC0 = 2'b01,
        ST_ACC1 = 2'b10,
        ST_DONE = 2'b11
    } dmem_state_t;

    function automatic logic [31:0] dmem_extend(input logic [31:0] w, input logic [2:0] opr);
        logic [31:0] r;
        case (opr)
            OPR_LB:  r = {{24{w[7]}}, w[7:0]};
            OPR_LH:  r = {{16{w[15]}}, w[15:0]};
            OPR_LW:  r = w;
            OPR_LBU: r = {24'h0, w[7:0]};
            OPR_LHU: r = {16'h0, w[15:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Byte-enabled synchronous RAM, one registered read per cycle, write-first on the addressed word.
module dmem_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                rdata_q[8*b +: 8]       <= wdata_i[8*b +: 8];
            end else begin
                rdata_q[8*b +: 8]       <= mem_q[addr_i][8*b +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder: byte/half/word loads and stores over dmem_bank with a one-shot response.
// Define MISALIGN_SPLIT_EN to split word-crossing accesses over two RAM cycles; otherwise they error.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_opr,
    input  logic [3:0]  req_opw,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;

    dmem_state_t   state_q, state_d;
    logic          we_q, err_q;
    logic [2:0]    opr_q;
    logic [1:0]    off_q;
    logic [AW-1:0] widx_q;
    logic [7:0]    be_q, be_d;
    logic [31:0]   wdata_q, lo_q;

    logic          accept, req_err, bad_op, misalign, spill;
    logic [3:0]    size_m;
    logic [1:0]    nbm1;
    logic [32:0]   last_byte;
    logic [63:0]   wdata64;
    logic [31:0]   lo_word;
    logic [AW-1:0] bank_addr;
    logic [3:0]    bank_be;
    logic [31:0]   bank_wdata, bank_rdata;

    assign accept = req_valid && (state_q == ST_IDLE);

    always_comb begin
        size_m = OPW_W;
        if (req_we) begin
            size_m = req_opw;
        end else begin
            case (req_opr[1:0])
                2'b00:   size_m = OPW_B;
                2'b01:   size_m = OPW_H;
                default: size_m = OPW_W;
            endcase
        end
        case (size_m)
            OPW_H:   nbm1 = 2'd1;
            OPW_W:   nbm1 = 2'd3;
            default: nbm1 = 2'd0;
        endcase
        last_byte = {1'b0, req_addr} + {31'h0, nbm1};
        bad_op    = req_we ? !(req_opw inside {OPW_B, OPW_H, OPW_W})
                           : (req_opr inside {3'b011, 3'b110, 3'b111});
`ifdef MISALIGN_SPLIT_EN
        misalign  = 1'b0;
`else
        misalign  = ((size_m == OPW_H) && req_addr[0]) ||
                    ((size_m == OPW_W) && (req_addr[1:0] != 2'b00));
`endif
        req_err   = bad_op || misalign || (last_byte >= MEM_BYTES);
        be_d      = {4'h0, size_m} << req_addr[1:0];
    end

    // Upper nibble of be_q holds the bytes that spill into the following word.
    assign spill = |be_q[7:4];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = req_err ? ST_DONE : ST_ACC0;
`ifdef MISALIGN_SPLIT_EN
            ST_ACC0: state_d = spill ? ST_ACC1 : ST_DONE;
`else
            ST_ACC0: state_d = ST_DONE;
`endif
            ST_ACC1: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            opr_q   <= '0;
            off_q   <= '0;
            widx_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                err_q   <= req_err;
                opr_q   <= req_opr;
                off_q   <= req_addr[1:0];
                widx_q  <= req_addr[AW+1:2];
                be_q    <= be_d;
                wdata_q <= req_wdata;
            end
            if (state_q == ST_ACC1) lo_q <= bank_rdata;
        end
    end

    // Writes are gated by rst so a reset during ACC1 leaves the next word untouched.
    always_comb begin
        wdata64    = {32'h0, wdata_q} << {off_q, 3'b000};
        bank_addr  = (state_q == ST_ACC1) ? widx_q + AW'(1) : widx_q;
        bank_wdata = (state_q == ST_ACC1) ? wdata64[63:32] : wdata64[31:0];
        bank_be    = '0;
        if (we_q && !rst) begin
            if (state_q == ST_ACC0) bank_be = be_q[3:0];
            if (state_q == ST_ACC1) bank_be = be_q[7:4];
        end
    end

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_bank (
        .clk_i   (clk),
        .addr_i  (bank_addr),
        .be_i    (bank_be),
        .wdata_i (bank_wdata),
        .rdata_o (bank_rdata)
    );

    assign lo_word   = spill ? lo_q : bank_rdata;
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !we_q && !err_q)
                     ? dmem_extend(32'({bank_rdata, lo_word} >> {off_q, 3'b000}), opr_q)
                     : '0;

endmodule
